latch_bank_ctrl: RTL and testbench
==================================

LATCH_BANK_CTRL -- requirements
Module: latch_bank_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each latch entry and of the shared D bus.
REQ-002 Parameter: DEPTH, fixed at 4, number of latch entries; address width is 2.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req0, req1  input  1 each  write request; held high until the matching ack.
REQ-006 Port: addr0, addr1  input  2 each  target entry; stable while the matching req is high.
REQ-007 Port: data0, data1  input  WIDTH each  write data; stable while the matching req is high.
REQ-008 Port: ack0, ack1  output  1 each  one-cycle write-complete pulse.
REQ-009 Port: latch_en  output  DEPTH  one-hot enable to the external D-latch bank.
REQ-010 Port: latch_d  output  WIDTH  shared D bus to all latches.
REQ-011 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, SETUP, ENABLE, HOLD and DONE.
REQ-013 In IDLE with any req high at the clock edge, the FSM SHALL move to SETUP, grant one requester, and register its addr and data.
REQ-014 Arbitration SHALL be round-robin.
  - If only one req is high, that requester is granted.
  - If both are high, the requester not granted last time wins.
  - After reset, req0 wins the first tie.
REQ-015 SETUP SHALL last 1 cycle and drive latch_d with the captured data, with latch_en all-zero.
REQ-016 ENABLE SHALL last 1 cycle, with latch_en[captured addr] = 1 (exactly one bit) and latch_d unchanged.
REQ-017 HOLD SHALL last 1 cycle, with latch_en all-zero and latch_d unchanged.
REQ-018 DONE SHALL last 1 cycle, pulse the granted requester's ack, then return to IDLE.
REQ-019 Latency SHALL be as follows: req sampled at edge N gives SETUP in cycle N+1, ENABLE in N+2, HOLD in N+3, and ack in N+4 (default build).
REQ-020 latch_d SHALL hold the last captured data until the next grant and SHALL never change while latch_en is non-zero.
REQ-021 latch_en, ack0, ack1 and busy SHALL be registered outputs, free of glitches.
REQ-022 A req that arrives while busy SHALL be ignored until IDLE; it is not lost while it stays high.
REQ-023 A requester SHALL deassert req at the edge that ends DONE; a req still high in IDLE SHALL be treated as a new request.
REQ-024 An addr or data change while busy SHALL have no effect on the write in progress.
REQ-025 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-026 While rst is high, the following SHALL be forced immediately:
  - state = IDLE
  - latch_en = 0, latch_d = 0
  - ack0 = ack1 = busy = 0
  - round-robin pointer set so that req0 wins the next tie.
REQ-027 Reset during SETUP, ENABLE, HOLD or DONE SHALL abort the write with no ack issued.
REQ-028 After rst falls, the first edge SHALL re-sample the reqs from IDLE.

Configuration
REQ-029 Macro HOLD_STRETCH_EN SHALL control the HOLD duration.
  - Defined: HOLD lasts 2 cycles, ack arrives at N+5, and busy stays high for 5 cycles.
  - Undefined: HOLD lasts 1 cycle, as in REQ-017 and REQ-019.
  - All other behaviour is identical in both builds.

Verification
REQ-030 Single write: req0=1, addr0=2, data0=8'hA5 -> latch_d=8'hA5 from N+1, latch_en=4'b0100 only in N+2, ack0 pulse in N+4, busy high N+1..N+4.
REQ-031 Tie and fairness: req0 and req1 both held high continuously (addr 0 and 3) -> grants alternate req0, req1, req0; latch_en alternates 4'b0001 and 4'b1000; acks never overlap.
REQ-032 Request while busy: req1 rises in the ENABLE cycle of a req0 write -> req1 is granted at the edge after DONE, and its ack arrives 4 cycles after that grant edge.
REQ-033 Stability: addr0 and data0 change to 1 and 8'h3C during HOLD -> latch_en and latch_d show no change; the original write completes.
REQ-034 Async reset: rst pulses mid-cycle during ENABLE -> latch_en=0 immediately with no clock edge needed, no ack, busy=0, and the next tie goes to req0.
REQ-035 HOLD_STRETCH_EN build: repeat REQ-030 -> two-cycle HOLD, ack0 in N+5.

Source files
------------

// File: rtl/latch_bank_if.sv
// Bus bundle between the two write requesters, the latch bank controller and the
// external D-latch bank it drives.
interface latch_bank_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic             req0;
   logic             req1;
   logic [1:0]       addr0;
   logic [1:0]       addr1;
   logic [WIDTH-1:0] data0;
   logic [WIDTH-1:0] data1;
   logic             ack0;
   logic             ack1;
   logic [DEPTH-1:0] latch_en;
   logic [WIDTH-1:0] latch_d;
   logic             busy;

   modport master (
      output req0, req1, addr0, addr1, data0, data1,
      input  ack0, ack1, latch_en, latch_d, busy
   );

   modport slave (
      input  req0, req1, addr0, addr1, data0, data1,
      output ack0, ack1, latch_en, latch_d, busy
   );
endinterface

// File: rtl/latch_bank_ctrl.sv
// Round-robin write sequencer for a 4-entry external D-latch bank (SETUP/ENABLE/HOLD/DONE).
// Define HOLD_STRETCH_EN to stretch HOLD to two cycles.
module latch_bank_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   latch_bank_if.slave  bus
);
   localparam int DEPTH = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ENABLE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic             grant_r;
   logic             last_r;
   logic [1:0]       addr_r;
   logic             win_s;
   logic [1:0]       win_addr_s;
   logic [WIDTH-1:0] win_data_s;
`ifdef HOLD_STRETCH_EN
   logic             hold_cnt_r;
`endif

   function automatic logic [DEPTH-1:0] addr_onehot(input logic [1:0] a);
      addr_onehot = {{(DEPTH-1){1'b0}}, 1'b1} << a;
   endfunction

   // Round-robin winner: on a tie the requester not granted last time wins.
   always_comb begin
      win_s = 1'b0;
      if (bus.req0 && bus.req1) begin
         win_s = ~last_r;
      end else if (bus.req1) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
      win_addr_s = win_s ? bus.addr1 : bus.addr0;
      win_data_s = win_s ? bus.data1 : bus.data0;
   end

   // Next-state decode of the write sequence.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               next_state_s = SETUP;
            end else begin
               next_state_s = IDLE;
            end
         end
         SETUP:  next_state_s = ENABLE;
         ENABLE: next_state_s = HOLD;
         HOLD: begin
`ifdef HOLD_STRETCH_EN
            if (hold_cnt_r) begin
               next_state_s = DONE;
            end else begin
               next_state_s = HOLD;
            end
`else
            next_state_s = DONE;
`endif
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State, capture and registered outputs; outputs are decoded from next state so they align with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         grant_r      <= 1'b0;
         last_r       <= 1'b1;
         addr_r       <= 2'd0;
         bus.latch_d  <= '0;
         bus.latch_en <= '0;
         bus.ack0     <= 1'b0;
         bus.ack1     <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         bus.busy     <= (next_state_s != IDLE);
         bus.latch_en <= (next_state_s == ENABLE) ? addr_onehot(addr_r) : {DEPTH{1'b0}};
         bus.ack0     <= (next_state_s == DONE) && !grant_r;
         bus.ack1     <= (next_state_s == DONE) && grant_r;
         if ((state_r == IDLE) && (next_state_s == SETUP)) begin
            grant_r     <= win_s;
            last_r      <= win_s;
            addr_r      <= win_addr_s;
            bus.latch_d <= win_data_s;
         end
      end
   end

`ifdef HOLD_STRETCH_EN
   // Counts the two HOLD cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_r <= 1'b0;
      end else begin
         hold_cnt_r <= (state_r == HOLD) ? ~hold_cnt_r : 1'b0;
      end
   end
`endif
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Directed self-checking bench for latch_bank_ctrl; each output check compares
// {busy, ack1, ack0, latch_en, latch_d} against a hand-computed vector.
module tb_latch_bank_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

`ifdef HOLD_STRETCH_EN
   localparam int HOLD_CYC = 2;
`else
   localparam int HOLD_CYC = 1;
`endif

   latch_bank_if #(.WIDTH(8), .DEPTH(4)) bus ();

   latch_bank_ctrl #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [14:0] obs();
      return {bus.busy, bus.ack1, bus.ack0, bus.latch_en, bus.latch_d};
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.addr0 = 2'd0; bus.addr1 = 2'd0;
      bus.data0 = 8'h00; bus.data1 = 8'h00;
      tick; tick;
      checks++;
      if (obs() !== 15'h0000) begin
         errors++; $display("FAIL reset_outputs got %h exp %h", obs(), 15'h0000);
      end
      rst = 1'b0;
      tick;
      checks++;
      if (obs() !== 15'h0000) begin
         errors++; $display("FAIL reset_idle got %h exp %h", obs(), 15'h0000);
      end
   endtask

   task automatic test_single_write;
      bus.addr0 = 2'd2; bus.data0 = 8'hA5; bus.req0 = 1'b1;
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b0000, 8'hA5}) begin
         errors++; $display("FAIL sw_setup got %h exp %h", obs(), {1'b1, 2'b00, 4'b0000, 8'hA5});
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b0100, 8'hA5}) begin
         errors++; $display("FAIL sw_enable got %h exp %h", obs(), {1'b1, 2'b00, 4'b0100, 8'hA5});
      end
      for (int h = 0; h < HOLD_CYC; h++) begin
         tick;
         checks++;
         if (obs() !== {1'b1, 2'b00, 4'b0000, 8'hA5}) begin
            errors++; $display("FAIL sw_hold%0d got %h exp %h", h, obs(), {1'b1, 2'b00, 4'b0000, 8'hA5});
         end
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b01, 4'b0000, 8'hA5}) begin
         errors++; $display("FAIL sw_done got %h exp %h", obs(), {1'b1, 2'b01, 4'b0000, 8'hA5});
      end
      bus.req0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++;
         if (obs() !== {1'b0, 2'b00, 4'b0000, 8'hA5}) begin
            errors++; $display("FAIL sw_idle%0d got %h exp %h", i, obs(), {1'b0, 2'b00, 4'b0000, 8'hA5});
         end
      end
   endtask

   task automatic test_tie;
      logic [7:0] d;
      logic [3:0] en;
      logic [1:0] ak;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      bus.addr0 = 2'd0; bus.data0 = 8'h11;
      bus.addr1 = 2'd3; bus.data1 = 8'h22;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      for (int g = 0; g < 3; g++) begin
         d  = (g == 1) ? 8'h22   : 8'h11;
         en = (g == 1) ? 4'b1000 : 4'b0001;
         ak = (g == 1) ? 2'b10   : 2'b01;
         tick;
         checks++;
         if (obs() !== {1'b1, 2'b00, 4'b0000, d}) begin
            errors++; $display("FAIL tie_setup%0d got %h exp %h", g, obs(), {1'b1, 2'b00, 4'b0000, d});
         end
         tick;
         checks++;
         if (obs() !== {1'b1, 2'b00, en, d}) begin
            errors++; $display("FAIL tie_enable%0d got %h exp %h", g, obs(), {1'b1, 2'b00, en, d});
         end
         for (int h = 0; h < HOLD_CYC; h++) begin
            tick;
            checks++;
            if (obs() !== {1'b1, 2'b00, 4'b0000, d}) begin
               errors++; $display("FAIL tie_hold%0d got %h exp %h", g, obs(), {1'b1, 2'b00, 4'b0000, d});
            end
         end
         tick;
         checks++;
         if (obs() !== {1'b1, ak, 4'b0000, d}) begin
            errors++; $display("FAIL tie_done%0d got %h exp %h", g, obs(), {1'b1, ak, 4'b0000, d});
         end
         if (g == 2) begin
            bus.req0 = 1'b0; bus.req1 = 1'b0;
         end
         tick;
         checks++;
         if (obs() !== {1'b0, 2'b00, 4'b0000, d}) begin
            errors++; $display("FAIL tie_idle%0d got %h exp %h", g, obs(), {1'b0, 2'b00, 4'b0000, d});
         end
      end
   endtask

   task automatic test_busy_req;
      bus.addr0 = 2'd1; bus.data0 = 8'h5A; bus.req0 = 1'b1;
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b0000, 8'h5A}) begin
         errors++; $display("FAIL br_setup got %h exp %h", obs(), {1'b1, 2'b00, 4'b0000, 8'h5A});
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b0010, 8'h5A}) begin
         errors++; $display("FAIL br_enable got %h exp %h", obs(), {1'b1, 2'b00, 4'b0010, 8'h5A});
      end
      bus.addr1 = 2'd2; bus.data1 = 8'h77; bus.req1 = 1'b1;
      for (int h = 0; h < HOLD_CYC; h++) begin
         tick;
         checks++;
         if (obs() !== {1'b1, 2'b00, 4'b0000, 8'h5A}) begin
            errors++; $display("FAIL br_hold got %h exp %h", obs(), {1'b1, 2'b00, 4'b0000, 8'h5A});
         end
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b01, 4'b0000, 8'h5A}) begin
         errors++; $display("FAIL br_done0 got %h exp %h", obs(), {1'b1, 2'b01, 4'b0000, 8'h5A});
      end
      bus.req0 = 1'b0;
      tick;
      checks++;
      if (obs() !== {1'b0, 2'b00, 4'b0000, 8'h5A}) begin
         errors++; $display("FAIL br_idle got %h exp %h", obs(), {1'b0, 2'b00, 4'b0000, 8'h5A});
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b0000, 8'h77}) begin
         errors++; $display("FAIL br_grant1 got %h exp %h", obs(), {1'b1, 2'b00, 4'b0000, 8'h77});
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b0100, 8'h77}) begin
         errors++; $display("FAIL br_enable1 got %h exp %h", obs(), {1'b1, 2'b00, 4'b0100, 8'h77});
      end
      for (int h = 0; h < HOLD_CYC; h++) begin
         tick;
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b10, 4'b0000, 8'h77}) begin
         errors++; $display("FAIL br_done1 got %h exp %h", obs(), {1'b1, 2'b10, 4'b0000, 8'h77});
      end
      bus.req1 = 1'b0;
      tick;
   endtask

   task automatic test_stability;
      bus.addr0 = 2'd2; bus.data0 = 8'h81; bus.req0 = 1'b1;
      tick;
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b0100, 8'h81}) begin
         errors++; $display("FAIL st_enable got %h exp %h", obs(), {1'b1, 2'b00, 4'b0100, 8'h81});
      end
      tick;
      bus.addr0 = 2'd1; bus.data0 = 8'h3C;
      for (int h = 1; h < HOLD_CYC; h++) begin
         tick;
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b01, 4'b0000, 8'h81}) begin
         errors++; $display("FAIL st_done got %h exp %h", obs(), {1'b1, 2'b01, 4'b0000, 8'h81});
      end
      bus.req0 = 1'b0;
      tick;
      checks++;
      if (obs() !== {1'b0, 2'b00, 4'b0000, 8'h81}) begin
         errors++; $display("FAIL st_idle got %h exp %h", obs(), {1'b0, 2'b00, 4'b0000, 8'h81});
      end
   endtask

   task automatic test_async_reset;
      bus.addr0 = 2'd3; bus.data0 = 8'h42; bus.req0 = 1'b1;
      tick;
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b1000, 8'h42}) begin
         errors++; $display("FAIL ar_enable got %h exp %h", obs(), {1'b1, 2'b00, 4'b1000, 8'h42});
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs() !== 15'h0000) begin
         errors++; $display("FAIL ar_immediate got %h exp %h", obs(), 15'h0000);
      end
      bus.req0 = 1'b0;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (obs() !== 15'h0000) begin
            errors++; $display("FAIL ar_no_ack%0d got %h exp %h", i, obs(), 15'h0000);
         end
      end
      bus.addr1 = 2'd1; bus.data1 = 8'h99;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b0000, 8'h42}) begin
         errors++; $display("FAIL ar_tie_req0 got %h exp %h", obs(), {1'b1, 2'b00, 4'b0000, 8'h42});
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b00, 4'b1000, 8'h42}) begin
         errors++; $display("FAIL ar_tie_enable got %h exp %h", obs(), {1'b1, 2'b00, 4'b1000, 8'h42});
      end
      for (int h = 0; h < HOLD_CYC; h++) begin
         tick;
      end
      tick;
      checks++;
      if (obs() !== {1'b1, 2'b01, 4'b0000, 8'h42}) begin
         errors++; $display("FAIL ar_tie_done got %h exp %h", obs(), {1'b1, 2'b01, 4'b0000, 8'h42});
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick;
   endtask

   initial begin
      clk = 1'b0;
      checks = 0;
      errors = 0;
      test_reset;
      test_single_write;
      test_tie;
      test_busy_req;
      test_stability;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
